uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the uart transmitter instances and consumes one txd lane. It takes the asynchronous serial line, synchronises it, and samples each bit at mid-bit time. It supports the same frame format as the transmitter (5–8 data bits, LSB first, optional odd/even parity, one stop bit) and presents each byte with a single-cycle valid strobe and error flags. It is used for loopback checking of uart_top and as the receive half of the two-way link.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync.sv | 37 +++
 rtl/uart_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-format helpers.
// The bit-length helper is shared with the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } uart_state_e;

   localparam logic [1:0] BL_5 = 2'b00;
   localparam logic [1:0] BL_6 = 2'b01;
   localparam logic [1:0] BL_7 = 2'b10;
   localparam logic [1:0] BL_8 = 2'b11;

   // Maps the two-bit length code onto the number of data bits (5..8).
   function automatic logic [3:0] bit_count(input logic [1:0] code);
      return 4'd5 + {2'b00, code};
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an idle-high serial line, with falling-edge detect
// on the synchronised output.
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic m_clock,
   input  logic p_reset,
   input  logic din_i,
   output logic dout_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   // Reset to all ones so a line that is idle at reset release never looks like a start.
   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   always_comb begin
      dout_o = sync_q[SYNC_STAGES-1];
      fall_o = prev_q & ~sync_q[SYNC_STAGES-1];
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling, 5..8 data bits LSB first, optional parity,
// one stop bit, single-cycle valid strobe with parity and framing error flags.
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DIV_W       = 16
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             RxD_i,
   input  logic [DIV_W-1:0] Freq_Divide_Param_i,
   input  logic [1:0]       Rx_BitLength_i,
   input  logic             Rx_ParityEN_i,
   input  logic             Rx_OddParity_i,
   input  logic             Rx_Enable_i,
   output logic [7:0]       Rx_Data_o,
   output logic             Rx_Valid_o,
   output logic             Rx_ParityErr_o,
   output logic             Rx_FrameErr_o,
   output logic             Rx_Busy_o
);

   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   uart_state_e      state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
   logic [3:0]       nbits_q, nbits_d;
   logic             par_en_q, par_en_d, odd_q, odd_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d, data_q, data_d;
   logic             frame_perr_q, frame_perr_d;
   logic             valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
   logic             rxs, rx_fall, cnt_zero;

   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .m_clock (m_clock),
      .p_reset (p_reset),
      .din_i   (RxD_i),
      .dout_o  (rxs),
      .fall_o  (rx_fall)
   );

   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) begin
         cnt_q        <= '0;
         div_q        <= '0;
         nbits_q      <= '0;
         par_en_q     <= 1'b0;
         odd_q        <= 1'b0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         frame_perr_q <= 1'b0;
         valid_q      <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         nbits_q      <= nbits_d;
         par_en_q     <= par_en_d;
         odd_q        <= odd_d;
         bit_idx_q    <= bit_idx_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         frame_perr_q <= frame_perr_d;
         valid_q      <= valid_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      nbits_d      = nbits_q;
      par_en_d     = par_en_q;
      odd_d        = odd_q;
      bit_idx_d    = bit_idx_q;
      shift_d      = shift_q;
      data_d       = data_q;
      frame_perr_d = frame_perr_q;
      valid_d      = 1'b0;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      cnt_zero     = (cnt_q == '0);

      // Outside IDLE every state waits on the bit counter before its sample point.
      if (state_q != IDLE && state_q != WAIT_HIGH && !cnt_zero) begin
         cnt_d = cnt_q - CNT_ONE;
      end

      case (state_q)
         IDLE: begin
            if (Rx_Enable_i && rx_fall) begin
               state_d      = START;
               cnt_d        = Freq_Divide_Param_i >> 1;
               div_d        = Freq_Divide_Param_i;
               nbits_d      = bit_count(Rx_BitLength_i);
               par_en_d     = Rx_ParityEN_i;
               odd_d        = Rx_OddParity_i;
               bit_idx_d    = '0;
               shift_d      = '0;
               frame_perr_d = 1'b0;
            end
         end
         START: begin
            if (cnt_zero) begin
               if (rxs) begin
                  state_d = IDLE;
               end else begin
                  state_d   = DATA;
                  cnt_d     = div_q - CNT_ONE;
                  bit_idx_d = '0;
               end
            end
         end
         DATA: begin
            if (cnt_zero) begin
               shift_d[bit_idx_q] = rxs;
               cnt_d              = div_q - CNT_ONE;
               if ({1'b0, bit_idx_q} == nbits_q - 4'd1) begin
                  state_d = par_en_q ? PARITY : STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (cnt_zero) begin
               frame_perr_d = ((^shift_q) ^ rxs) != odd_q;
               cnt_d        = div_q - CNT_ONE;
               state_d      = STOP;
            end
         end
         STOP: begin
            if (cnt_zero) begin
               valid_d = 1'b1;
               data_d  = shift_q;
               perr_d  = frame_perr_q;
               ferr_d  = ~rxs;
               state_d = rxs ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Disabling abandons whatever frame is in flight without touching the outputs.
      if (!Rx_Enable_i) begin
         state_d = IDLE;
         valid_d = 1'b0;
         data_d  = data_q;
         perr_d  = perr_q;
         ferr_d  = ferr_q;
      end
   end

   always_comb begin
      Rx_Data_o      = data_q;
      Rx_Valid_o     = valid_q;
      Rx_ParityErr_o = perr_q;
      Rx_FrameErr_o  = ferr_q;
      Rx_Busy_o      = (state_q != IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are serialised bit by bit, expectations are
// queued from a reference model and checked when the receiver strobes.
module tb_uart_rx;

   logic        m_clock = 1'b0;
   logic        p_reset = 1'b1;
   logic        rxd     = 1'b1;
   logic [15:0] div_in  = 16'd32;
   logic [1:0]  bl      = 2'b11;
   logic        pen     = 1'b0;
   logic        podd    = 1'b0;
   logic        en      = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_perr, rx_ferr, rx_busy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_fall   = 0;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         lat;
   } exp_t;

   exp_t sb[$];

   uart_rx #(.SYNC_STAGES(2), .DIV_W(16)) dut (
      .m_clock             (m_clock),
      .p_reset             (p_reset),
      .RxD_i               (rxd),
      .Freq_Divide_Param_i (div_in),
      .Rx_BitLength_i      (bl),
      .Rx_ParityEN_i       (pen),
      .Rx_OddParity_i      (podd),
      .Rx_Enable_i         (en),
      .Rx_Data_o           (rx_data),
      .Rx_Valid_o          (rx_valid),
      .Rx_ParityErr_o      (rx_perr),
      .Rx_FrameErr_o       (rx_ferr),
      .Rx_Busy_o           (rx_busy)
   );

   always #5 m_clock = ~m_clock;
   always @(posedge m_clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer: every strobe must match the oldest queued frame.
   always @(negedge m_clock) begin
      if (rx_valid === 1'b1) begin
         n_assert++;
         assert (sb.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_strobe: observed data %0h, expected no strobe", rx_data);
         end
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            $display("strobe: data %02h perr %0d ferr %0d (exp %02h %0d %0d)",
                     rx_data, rx_perr, rx_ferr, e.data, e.perr, e.ferr);
            chk("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            chk("rx_perr", {31'd0, rx_perr}, {31'd0, e.perr});
            chk("rx_ferr", {31'd0, rx_ferr}, {31'd0, e.ferr});
            if (e.lat >= 0) chk("latency", cyc - t_fall - 1, e.lat);
         end
      end
   end

   // Serialises one frame; abort_at >= 0 stops before that bit index (0 = start bit)
   // and queues nothing. scramble changes the live config after the start bit.
   task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                             input int abort_at, input bit check_lat, input bit scramble);
      int         n, d;
      logic [7:0] mask, m;
      logic       bits[$];
      exp_t       e;
      logic [15:0] div_save;
      logic [1:0]  bl_save;
      n        = 5 + int'(bl);
      d        = int'(div_in);
      mask     = 8'hFF >> (8 - n);
      m        = data & mask;
      div_save = div_in;
      bl_save  = bl;
      bits.push_back(1'b0);
      for (int i = 0; i < n; i++) bits.push_back(data[i]);
      if (pen) bits.push_back(par_bit);
      bits.push_back(stop_bit);
      e.data = m;
      e.perr = pen ? (((^m) ^ par_bit) != podd) : 1'b0;
      e.ferr = ~stop_bit;
      e.lat  = check_lat ? (2 + (d >> 1) + (n + int'(pen) + 1) * d + 1) : -1;
      if (abort_at < 0) sb.push_back(e);
      @(posedge m_clock); #1;
      for (int i = 0; i < bits.size(); i++) begin
         if (i == abort_at) return;
         rxd = bits[i];
         if (i == 0) t_fall = cyc;
         if (i == 1 && scramble) begin
            div_in = 16'd7;
            bl     = 2'b00;
         end
         repeat (d) @(posedge m_clock);
         #1;
      end
      if (scramble) begin
         div_in = div_save;
         bl     = bl_save;
      end
      $display("sent frame %02h bits %0d par_en %0d stop %0d", data, n, pen, stop_bit);
   endtask

   task automatic drain(input string tag);
      int guard = 0;
      while (sb.size() != 0 && guard < 2000) begin
         @(posedge m_clock);
         guard++;
      end
      #1;
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge m_clock);
      #1;
      chk("reset_data",  {24'd0, rx_data}, 32'd0);
      chk("reset_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset_perr",  {31'd0, rx_perr}, 32'd0);
      chk("reset_ferr",  {31'd0, rx_ferr}, 32'd0);
      chk("reset_busy",  {31'd0, rx_busy}, 32'd0);
      p_reset = 1'b0;
      repeat (5) @(posedge m_clock);
      #1;

      // Basic 8N1 frame with latency check, then back-to-back frames.
      send_frame(8'h38, 1'b0, 1'b1, -1, 1'b1, 1'b0);
      drain("drain_basic");
      send_frame(8'hC3, 1'b0, 1'b1, -1, 1'b1, 1'b0);
      send_frame(8'h5A, 1'b0, 1'b1, -1, 1'b1, 1'b1);
      drain("drain_b2b");

      // Parity, even then odd.
      pen  = 1'b1;
      podd = 1'b0;
      send_frame(8'h39, 1'b0, 1'b1, -1, 1'b1, 1'b0);
      send_frame(8'h39, 1'b1, 1'b1, -1, 1'b0, 1'b0);
      podd = 1'b1;
      send_frame(8'h00, 1'b1, 1'b1, -1, 1'b0, 1'b0);
      send_frame(8'h00, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      drain("drain_parity");
      pen  = 1'b0;
      podd = 1'b0;

      // Short formats; upper bits of the sent byte must not leak through.
      bl = 2'b00;
      send_frame(8'hF5, 1'b0, 1'b1, -1, 1'b1, 1'b0);
      bl = 2'b10;
      send_frame(8'h7F, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      drain("drain_short");
      bl = 2'b11;

      // Framing error followed by a held-low line.
      send_frame(8'h81, 1'b0, 1'b0, -1, 1'b0, 1'b0);
      repeat (100) @(posedge m_clock);
      #1;
      chk("break_busy", {31'd0, rx_busy}, 32'd1);
      rxd = 1'b1;
      repeat (5) @(posedge m_clock);
      #1;
      chk("break_release_busy", {31'd0, rx_busy}, 32'd0);
      chk("hold_data", {24'd0, rx_data}, 32'h81);
      chk("hold_ferr", {31'd0, rx_ferr}, 32'd1);
      drain("drain_break");

      // Short glitch is rejected at the start-bit sample.
      @(posedge m_clock); #1;
      rxd = 1'b0;
      repeat (10) @(posedge m_clock);
      #1;
      rxd = 1'b1;
      repeat (3) @(posedge m_clock);
      #1;
      chk("glitch_busy_mid", {31'd0, rx_busy}, 32'd1);
      repeat (40) @(posedge m_clock);
      #1;
      chk("glitch_busy_end", {31'd0, rx_busy}, 32'd0);

      // Reset at data bit 3.
      send_frame(8'h66, 1'b0, 1'b1, 4, 1'b0, 1'b0);
      p_reset = 1'b1;
      rxd     = 1'b1;
      repeat (2) @(posedge m_clock);
      #1;
      chk("abort_rst_busy", {31'd0, rx_busy}, 32'd0);
      chk("abort_rst_data", {24'd0, rx_data}, 32'd0);
      p_reset = 1'b0;
      repeat (96) @(posedge m_clock);
      #1;
      send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b1, 1'b0);
      drain("drain_after_reset");

      // Enable dropped mid-frame.
      send_frame(8'h3C, 1'b0, 1'b1, 6, 1'b0, 1'b0);
      en  = 1'b0;
      rxd = 1'b1;
      @(posedge m_clock); #1;
      chk("abort_en_busy", {31'd0, rx_busy}, 32'd0);
      repeat (100) @(posedge m_clock);
      #1;
      en = 1'b1;
      repeat (4) @(posedge m_clock);
      #1;
      send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0, 1'b0);
      drain("drain_after_enable");
      chk("final_data", {24'd0, rx_data}, 32'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
